ann_host_sequencer: RTL and testbench
=====================================

Name: ann_host_sequencer

Overview:
- Host-side controller that drives the ANN accelerator's pin-level interface through one complete run:
  - optional kd-tree load
  - query load
  - FSM start and wait for done
  - best-array readout
- Sits between a word-stream source/sink (test harness or an external MCU bridge) and the accelerator's in/out FIFOs and control strobes.
- One command runs one job.

Parameters:
- DATA_W, 11, FIFO word width (matches in_fifo_wdata/out_fifo_rdata).
- CNT_W, 16, width of word counters in the command.
- TIMEOUT_W, 20, width of the fsm_done watchdog counter (used only with the optional feature).

Ports:
- io_clk  in  1  single clock.
- io_rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_load_tree  in  1  1 = run LOAD_TREE phase.
- cmd_tree_words  in  CNT_W  tree words to push.
- cmd_query_words  in  CNT_W  query words to push.
- cmd_result_words  in  CNT_W  result words to drain.
- src_valid  in  1  source word valid.
- src_data  in  DATA_W  source word.
- src_ready  out  1  sequencer accepts word.
- snk_valid  out  1  result word valid.
- snk_data  out  DATA_W  result word.
- snk_ready  in  1  sink accepts word.
- in_fifo_wenq  out  1  accelerator input FIFO enqueue.
- in_fifo_wdata  out  DATA_W  enqueue data.
- in_fifo_wfull_n  in  1  input FIFO not full.
- out_fifo_deq  out  1  output FIFO dequeue.
- out_fifo_rdata  in  DATA_W  output FIFO head (first-word fall-through).
- out_fifo_rempty_n  in  1  output FIFO not empty.
- load_kdtree  out  1  level, high during LOAD_TREE.
- fsm_start  out  1  one-cycle pulse.
- fsm_done  in  1  accelerator done level.
- send_best_arr  out  1  level, high during DRAIN.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse on job completion.
- err_timeout  out  1  sticky watchdog flag (optional feature).

Behaviour:
- Reset (io_rst=1 at posedge): state IDLE, all counters 0. All outputs 0 except cmd_ready=1. Reset mid-job aborts immediately; no further wenq/deq pulses are issued.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch all cmd_* fields.
  - Next state: LOAD_TREE if cmd_load_tree and tree_words≠0, else LOAD_QUERY.
- LOAD_TREE:
  - load_kdtree=1.
  - src_ready = in_fifo_wfull_n & (remaining≠0).
  - in_fifo_wenq = src_valid & src_ready; in_fifo_wdata = src_data (combinational pass-through, zero latency).
  - Each enqueue decrements remaining. The cycle the last word enqueues, go to LOAD_QUERY.
  - load_kdtree drops the cycle after the last tree word.
- LOAD_QUERY:
  - Same handshake as LOAD_TREE, with load_kdtree=0.
  - query_words=0 skips straight to START.
- START: fsm_start=1 for exactly one cycle, then WAIT_DONE.
- WAIT_DONE:
  - Ignore fsm_done during the START cycle.
  - On first fsm_done=1 sampled in WAIT_DONE, go to DRAIN.
  - fsm_done already high before START is not honoured until WAIT_DONE.
- DRAIN:
  - send_best_arr=1.
  - snk_valid = out_fifo_rempty_n & (remaining≠0); snk_data = out_fifo_rdata.
  - out_fifo_deq = snk_valid & snk_ready.
  - Decrement remaining per deq; after the last deq go to FINISH.
  - result_words=0 goes directly to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- Invariants:
  - in_fifo_wenq never asserts while in_fifo_wfull_n=0.
  - out_fifo_deq never asserts while out_fifo_rempty_n=0.
  - src_ready=0 and snk_valid=0 outside their phases.
- Counters never wrap; a count of 0 means the phase is skipped.
- cmd_valid outside IDLE is ignored.

Optional Feature:
- Macro ANN_SEQ_TIMEOUT_EN.
- When defined:
  - A TIMEOUT_W-bit counter clears on entering WAIT_DONE and increments each cycle there.
  - When it reaches all-ones with fsm_done still 0: set err_timeout (sticky until io_rst), pulse done, return to IDLE. DRAIN is skipped.
- When undefined: WAIT_DONE waits indefinitely; err_timeout is tied to 0; no counter logic exists.

Test Plan:
- Full job: tree=4, query=3, result=2, source always valid, wfull_n=1, sink ready.
  - Expect exactly 7 wenq, each carrying the source words in order.
  - load_kdtree high for exactly 4 wenq cycles.
  - One fsm_start pulse.
  - After fsm_done, 2 deq with snk_data equal to the rdata values; done pulse; then IDLE.
- Backpressure: hold wfull_n=0 for 5 cycles mid-load and toggle src_valid.
  - Expect no wenq while full, no lost or duplicated words, and order preserved.
- Drain stall: rempty_n toggles 1/0 and snk_ready=0 for 3 cycles.
  - Expect deq only when rempty_n&snk_ready, snk_valid=0 while empty, and exactly result_words deqs.
- Skip paths: cmd_load_tree=0, query=0, result=0.
  - Expect no wenq, no load_kdtree, START→WAIT_DONE→FINISH.
- Reset mid-DRAIN: assert io_rst for 1 cycle.
  - Next cycle: IDLE, cmd_ready=1, send_best_arr=0, no deq.
- With ANN_SEQ_TIMEOUT_EN, TIMEOUT_W=4, fsm_done held 0.
  - err_timeout=1 after 15 WAIT_DONE cycles, done pulses, no send_best_arr.
  - Without the macro: still in WAIT_DONE after 100 cycles.

Source files
------------

// File: rtl/ann_host_sequencer.sv
// Host-side sequencer for the ANN accelerator: kd-tree load, query load, start/wait, result drain.
// Optional fsm_done watchdog is enabled by defining ANN_SEQ_TIMEOUT_EN.
module ann_host_sequencer #(
  parameter int DATA_W    = 11,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT_W = 20
) (
  input  logic              io_clk,
  input  logic              io_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load_tree,
  input  logic [CNT_W-1:0]  cmd_tree_words,
  input  logic [CNT_W-1:0]  cmd_query_words,
  input  logic [CNT_W-1:0]  cmd_result_words,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              snk_valid,
  output logic [DATA_W-1:0] snk_data,
  input  logic              snk_ready,
  output logic              in_fifo_wenq,
  output logic [DATA_W-1:0] in_fifo_wdata,
  input  logic              in_fifo_wfull_n,
  output logic              out_fifo_deq,
  input  logic [DATA_W-1:0] out_fifo_rdata,
  input  logic              out_fifo_rempty_n,
  output logic              load_kdtree,
  output logic              fsm_start,
  input  logic              fsm_done,
  output logic              send_best_arr,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD_TREE  = 3'd1;
  localparam logic [2:0] S_LOAD_QUERY = 3'd2;
  localparam logic [2:0] S_START      = 3'd3;
  localparam logic [2:0] S_WAIT_DONE  = 3'd4;
  localparam logic [2:0] S_DRAIN      = 3'd5;
  localparam logic [2:0] S_FINISH     = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] query_q, query_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             load_phase, drain_phase, rem_nz, rem_last;

  assign load_phase  = (state_q == S_LOAD_TREE) || (state_q == S_LOAD_QUERY);
  assign drain_phase = (state_q == S_DRAIN);
  assign rem_nz      = (remaining_q != '0);
  assign rem_last    = (remaining_q == CNT_W'(1));

  // Handshakes are gated by the remaining count so a phase can never over-run.
  assign src_ready     = load_phase & in_fifo_wfull_n & rem_nz;
  assign in_fifo_wenq  = src_valid & src_ready;
  assign in_fifo_wdata = load_phase ? src_data : '0;
  assign snk_valid     = drain_phase & out_fifo_rempty_n & rem_nz;
  assign snk_data      = drain_phase ? out_fifo_rdata : '0;
  assign out_fifo_deq  = snk_valid & snk_ready;

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign load_kdtree   = (state_q == S_LOAD_TREE);
  assign fsm_start     = (state_q == S_START);
  assign send_best_arr = drain_phase;
  assign done          = (state_q == S_FINISH);

`ifdef ANN_SEQ_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 err_q, err_d;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
  if (TIMEOUT_W < 1) begin : g_timeout_w_invalid
  end
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    query_d     = query_q;
    result_d    = result_q;
`ifdef ANN_SEQ_TIMEOUT_EN
    timer_d     = timer_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          query_d  = cmd_query_words;
          result_d = cmd_result_words;
          if (cmd_load_tree && (cmd_tree_words != '0)) begin
            state_d     = S_LOAD_TREE;
            remaining_d = cmd_tree_words;
          end else if (cmd_query_words != '0) begin
            state_d     = S_LOAD_QUERY;
            remaining_d = cmd_query_words;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_LOAD_TREE: begin
        if (in_fifo_wenq) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (rem_last) begin
            if (query_q != '0) begin
              state_d     = S_LOAD_QUERY;
              remaining_d = query_q;
            end else begin
              state_d = S_START;
            end
          end
        end
      end
      S_LOAD_QUERY: begin
        if (in_fifo_wenq) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (rem_last) state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT_DONE;
`ifdef ANN_SEQ_TIMEOUT_EN
        timer_d = '0;
`endif
      end
      S_WAIT_DONE: begin
        if (fsm_done) begin
          if (result_q != '0) begin
            state_d     = S_DRAIN;
            remaining_d = result_q;
          end else begin
            state_d = S_FINISH;
          end
        end
`ifdef ANN_SEQ_TIMEOUT_EN
        else begin
          // Last count value is reached on the final waiting cycle; abort without draining.
          timer_d = timer_q + 1'b1;
          if (timer_q == TIMER_LAST) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end
        end
`endif
      end
      S_DRAIN: begin
        if (out_fifo_deq) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (rem_last) state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      query_q     <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      query_q     <= query_d;
      result_q    <= result_d;
    end
  end

`ifdef ANN_SEQ_TIMEOUT_EN
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_ann_host_sequencer.sv
// Self-checking bench for ann_host_sequencer: table of jobs plus hand-written reset/timeout sequences.
module tb_ann_host_sequencer;

  logic        io_clk = 1'b0;
  logic        io_rst;
  logic        cmd_valid, cmd_ready, cmd_load_tree;
  logic [15:0] cmd_tree_words, cmd_query_words, cmd_result_words;
  logic        src_valid, src_ready, snk_valid, snk_ready;
  logic [10:0] src_data, snk_data, in_fifo_wdata, out_fifo_rdata;
  logic        in_fifo_wenq, in_fifo_wfull_n, out_fifo_deq, out_fifo_rempty_n;
  logic        load_kdtree, fsm_start, fsm_done, send_best_arr, busy, done, err_timeout;

  always #5 io_clk = ~io_clk;

  ann_host_sequencer #(.DATA_W(11), .CNT_W(16), .TIMEOUT_W(4)) dut (
    .io_clk(io_clk), .io_rst(io_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load_tree(cmd_load_tree),
    .cmd_tree_words(cmd_tree_words), .cmd_query_words(cmd_query_words),
    .cmd_result_words(cmd_result_words),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
    .in_fifo_wenq(in_fifo_wenq), .in_fifo_wdata(in_fifo_wdata), .in_fifo_wfull_n(in_fifo_wfull_n),
    .out_fifo_deq(out_fifo_deq), .out_fifo_rdata(out_fifo_rdata),
    .out_fifo_rempty_n(out_fifo_rempty_n),
    .load_kdtree(load_kdtree), .fsm_start(fsm_start), .fsm_done(fsm_done),
    .send_best_arr(send_best_arr), .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  typedef struct {
    bit load_tree;
    int tree, query, result;
    bit stall_in, stall_out, spam, done_early;
    int exp_wenq, exp_kd, exp_deq, exp_gap;
  } job_t;

  typedef struct {
    logic [10:0] data;
    logic        kd;
  } wexp_t;

  job_t        jobs[6];
  job_t        cur;
  logic [10:0] src_words[$];
  wexp_t       exp_wq[$];
  logic [10:0] fifo_q[$];
  logic [10:0] exp_rq[$];

  int n_checks = 0, n_fail = 0;
  int src_idx, job_cyc, drain_cyc, done_cnt, start_cyc, done_cyc;
  int n_wenq, n_deq, n_kd, n_start, n_done;
  bit stall_in, stall_out, spam, spam_on, hold_sink, no_done, done_level;
  bit rst_req, cmd_pending, done_seen, err_at_done;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    io_rst    = rst_req;
    cmd_valid = cmd_pending || spam_on;
    if (cmd_pending) begin
      cmd_load_tree    = cur.load_tree;
      cmd_tree_words   = 16'(cur.tree);
      cmd_query_words  = 16'(cur.query);
      cmd_result_words = 16'(cur.result);
    end else begin
      cmd_load_tree    = 1'b1;
      cmd_tree_words   = 16'd7;
      cmd_query_words  = 16'd7;
      cmd_result_words = 16'd7;
    end
    src_valid         = (!stall_in || (job_cyc % 2 == 0)) && (src_idx < src_words.size());
    src_data          = src_valid ? src_words[src_idx] : 11'h0;
    in_fifo_wfull_n   = !(stall_in && job_cyc >= 3 && job_cyc < 8);
    out_fifo_rempty_n = (fifo_q.size() != 0) && (!stall_out || (drain_cyc % 2 == 1));
    out_fifo_rdata    = (fifo_q.size() != 0) ? fifo_q[0] : 11'h0;
    snk_ready         = !hold_sink && (!stall_out || drain_cyc >= 3);
    fsm_done          = done_level;
  endtask

  task automatic monitor();
    wexp_t e;
    if (cmd_pending) begin
      checkOutput("cmd_ready_idle", 32'(cmd_ready), 1);
      cmd_pending = 1'b0;
      spam_on     = spam;
    end
    if (!in_fifo_wfull_n) checkOutput("no_wenq_when_full", 32'(in_fifo_wenq), 0);
    if (!out_fifo_rempty_n) begin
      checkOutput("snk_valid_when_empty", 32'(snk_valid), 0);
      checkOutput("no_deq_when_empty", 32'(out_fifo_deq), 0);
    end
    if (in_fifo_wenq) begin
      n_wenq++;
      if (exp_wq.size() == 0) checkOutput("wenq_unexpected", 1, 0);
      else begin
        e = exp_wq.pop_front();
        checkOutput("wenq_data", 32'(in_fifo_wdata), 32'(e.data));
        checkOutput("wenq_load_kdtree", 32'(load_kdtree), 32'(e.kd));
      end
      src_idx++;
    end
    if (load_kdtree) n_kd++;
    if (fsm_start) begin
      n_start++;
      start_cyc = job_cyc;
      if (!no_done && !done_level) done_cnt = 3;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) done_level = 1'b1;
    end
    if (out_fifo_deq) begin
      n_deq++;
      if (exp_rq.size() == 0) checkOutput("deq_unexpected", 1, 0);
      else checkOutput("deq_data", 32'(snk_data), 32'(exp_rq.pop_front()));
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (send_best_arr) drain_cyc++;
    if (done) begin
      n_done++;
      done_seen   = 1'b1;
      done_cyc    = job_cyc;
      err_at_done = err_timeout;
      done_level  = 1'b0;
      spam_on     = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge io_clk);
    applyStimulus();
    #1;
    monitor();
    job_cyc++;
  endtask

  task automatic startJob(input job_t j);
    int eff_tree;
    logic [10:0] w;
    cur = j;
    job_cyc = 0; drain_cyc = 0; done_cnt = 0;
    n_wenq = 0; n_deq = 0; n_kd = 0; n_start = 0; n_done = 0;
    start_cyc = -1; done_cyc = -1; done_seen = 1'b0; err_at_done = 1'b0;
    stall_in = j.stall_in; stall_out = j.stall_out; spam = j.spam;
    done_level = j.done_early; cmd_pending = 1'b1;
    src_words.delete(); exp_wq.delete(); fifo_q.delete(); exp_rq.delete();
    src_idx = 0;
    eff_tree = (j.load_tree && j.tree != 0) ? j.tree : 0;
    for (int i = 0; i < eff_tree; i++) begin
      w = 11'($urandom_range(0, 2047));
      src_words.push_back(w);
      exp_wq.push_back('{data: w, kd: 1'b1});
    end
    for (int i = 0; i < j.query; i++) begin
      w = 11'($urandom_range(0, 2047));
      src_words.push_back(w);
      exp_wq.push_back('{data: w, kd: 1'b0});
    end
    for (int i = 0; i < j.result; i++) begin
      w = 11'($urandom_range(0, 2047));
      fifo_q.push_back(w);
      exp_rq.push_back(w);
    end
  endtask

  task automatic runJob(input job_t j);
    startJob(j);
    for (int c = 0; c < 300 && !done_seen; c++) tick();
    checkOutput("job_completed", 32'(done_seen), 1);
    checkOutput("wenq_count", n_wenq, j.exp_wenq);
    checkOutput("deq_count", n_deq, j.exp_deq);
    checkOutput("start_pulses", n_start, 1);
    checkOutput("done_pulses", n_done, 1);
    checkOutput("src_left", exp_wq.size(), 0);
    checkOutput("fifo_left", fifo_q.size(), 0);
    if (j.exp_kd >= 0) checkOutput("load_kdtree_cycles", n_kd, j.exp_kd);
    if (j.exp_gap >= 0) checkOutput("start_to_done", done_cyc - start_cyc, j.exp_gap);
    stall_in = 1'b0; stall_out = 1'b0; spam = 1'b0;
    tick();
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("idle_done", 32'(done), 0);
  endtask

  initial begin
    job_t hj;
    //             lt tree q  r  sIn sOut spam early wenq kd  deq gap
    jobs[0] = '{1'b1, 4, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0, 7,  4, 2,  7};
    jobs[1] = '{1'b1, 3, 5, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8, -1, 1, -1};
    jobs[2] = '{1'b0, 0, 2, 4, 1'b0, 1'b1, 1'b0, 1'b0, 2,  0, 4, -1};
    jobs[3] = '{1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0,  0, 0,  2};
    jobs[4] = '{1'b1, 0, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0, 2,  0, 1, -1};
    jobs[5] = '{1'b0, 5, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 3, -1};

    stall_in = 0; stall_out = 0; spam = 0; spam_on = 0; hold_sink = 0; no_done = 0;
    done_level = 0; cmd_pending = 0; src_idx = 0; job_cyc = 0; drain_cyc = 0; done_cnt = 0;
    cur = jobs[3];
    rst_req = 1'b1;
    tick();
    tick();
    rst_req = 1'b0;
    tick();
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_src_ready", 32'(src_ready), 0);
    checkOutput("rst_snk_valid", 32'(snk_valid), 0);
    checkOutput("rst_load_kdtree", 32'(load_kdtree), 0);
    checkOutput("rst_fsm_start", 32'(fsm_start), 0);
    checkOutput("rst_send_best_arr", 32'(send_best_arr), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err_timeout", 32'(err_timeout), 0);

    for (int i = 0; i < 6; i++) begin
      $display("[TB] job %0d", i);
      runJob(jobs[i]);
    end

    // Reset in the middle of DRAIN with the sink stalled
    $display("[TB] reset during drain");
    hj = '{1'b0, 0, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 0, -1};
    hold_sink = 1'b1;
    startJob(hj);
    for (int c = 0; c < 50 && drain_cyc == 0; c++) tick();
    checkOutput("reached_drain", 32'(drain_cyc != 0), 1);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    hold_sink = 1'b0;
    tick();
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("post_rst_send_best_arr", 32'(send_best_arr), 0);
    checkOutput("post_rst_deq", 32'(out_fifo_deq), 0);
    checkOutput("post_rst_busy", 32'(busy), 0);
    tick();
    checkOutput("post_rst_deq_2", 32'(out_fifo_deq), 0);
    checkOutput("post_rst_deq_total", n_deq, 0);

    // fsm_done never arrives
    hj = '{1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, -1};
    no_done = 1'b1;
    startJob(hj);
`ifdef ANN_SEQ_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    for (int c = 0; c < 60 && !done_seen; c++) tick();
    checkOutput("timeout_done_seen", 32'(done_seen), 1);
    checkOutput("timeout_done_cycle", done_cyc, 17);
    checkOutput("timeout_err_at_done", 32'(err_at_done), 1);
    checkOutput("timeout_no_drain", drain_cyc, 0);
    tick();
    checkOutput("timeout_sticky", 32'(err_timeout), 1);
    checkOutput("timeout_idle", 32'(cmd_ready), 1);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
    checkOutput("timeout_cleared", 32'(err_timeout), 0);
`else
    $display("[TB] wait without watchdog");
    for (int c = 0; c < 100; c++) tick();
    checkOutput("wait_still_busy", 32'(busy), 1);
    checkOutput("wait_no_done", n_done, 0);
    checkOutput("wait_no_drain", 32'(send_best_arr), 0);
    checkOutput("wait_err_low", 32'(err_timeout), 0);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
    checkOutput("wait_rst_idle", 32'(cmd_ready), 1);
`endif
    no_done = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
